// File: rtl/counter_ir_capture.sv
// IR/pulse input capture: measures high time and rising-to-rising period in i_clk cycles.
// Optional glitch filter enabled by defining COUNTER_IR_CAPTURE_GLITCH_FILTER_EN.
module counter_ir_capture #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic             i_invert,
  input  logic             i_ir_din,
  input  logic [CNT_W-1:0] i_timeout_value,
  output logic [CNT_W-1:0] o_cap_high,
  output logic [CNT_W-1:0] o_cap_period,
  output logic             o_cap_valid,
  input  logic             i_cap_ready,
  input  logic             i_ovr_clr,
  output logic             o_cap_overrun,
  output logic             o_timeout,
  output logic             o_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t             state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic               lvl;
  logic               s;
  logic               s_d_q;
  logic               rise;
  logic               fall;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_inc;
  logic [CNT_W-1:0]   hi_len_q;
  logic               timeout_hit;
  logic               cand;
  logic               drop;
  logic               accept;

  // Metastability synchronizer for the asynchronous pin
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_ir_din};
    end
  end

`ifdef COUNTER_IR_CAPTURE_GLITCH_FILTER_EN
  localparam int unsigned FILT_CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic               filt_q;
  logic [FILT_CW-1:0] filt_cnt_q;

  // Filtered level follows the input only after FILT_LEN consecutive differing samples
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      filt_q     <= 1'b0;
      filt_cnt_q <= '0;
    end else if (sync_q[SYNC_STAGES-1] == filt_q) begin
      filt_cnt_q <= '0;
    end else if (filt_cnt_q == FILT_CW'(FILT_LEN - 1)) begin
      filt_q     <= sync_q[SYNC_STAGES-1];
      filt_cnt_q <= '0;
    end else begin
      filt_cnt_q <= filt_cnt_q + FILT_CW'(1);
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync_q[SYNC_STAGES-1];
`endif

  assign s    = lvl ^ i_invert;
  assign rise = s & ~s_d_q;
  assign fall = ~s & s_d_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s_d_q <= 1'b0;
    end else begin
      s_d_q <= s;
    end
  end

  // Saturating increment so very long phases never wrap
  assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  assign timeout_hit = (i_timeout_value != '0) && (cnt_q == i_timeout_value);

  // Measurement FSM; timeout wins over a coincident edge
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_len_q  <= '0;
      o_timeout <= 1'b0;
      o_busy    <= 1'b0;
    end else begin
      o_timeout <= 1'b0;
      if (!i_enable) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        o_busy  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            cnt_q <= '0;
            if (rise) begin
              state_q <= HIGH;
              cnt_q   <= CNT_W'(1);
              o_busy  <= 1'b1;
            end
          end
          HIGH: begin
            if (timeout_hit) begin
              state_q   <= IDLE;
              cnt_q     <= '0;
              o_busy    <= 1'b0;
              o_timeout <= 1'b1;
            end else begin
              cnt_q <= cnt_inc;
              if (fall) begin
                hi_len_q <= cnt_q;
                state_q  <= LOW;
              end
            end
          end
          LOW: begin
            if (timeout_hit) begin
              state_q   <= IDLE;
              cnt_q     <= '0;
              o_busy    <= 1'b0;
              o_timeout <= 1'b1;
            end else if (rise) begin
              state_q <= HIGH;
              cnt_q   <= CNT_W'(1);
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
            o_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cand   = i_enable && (state_q == LOW) && rise && !timeout_hit;
  assign accept = o_cap_valid & i_cap_ready;
  assign drop   = cand & o_cap_valid & ~i_cap_ready;

  // Result holding register with valid/ready handshake
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_cap_high   <= '0;
      o_cap_period <= '0;
      o_cap_valid  <= 1'b0;
    end else if (cand && !drop) begin
      o_cap_high   <= hi_len_q;
      o_cap_period <= cnt_q;
      o_cap_valid  <= 1'b1;
    end else if (accept) begin
      o_cap_valid  <= 1'b0;
    end
  end

  // Sticky overrun; a new drop beats a simultaneous clear
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_cap_overrun <= 1'b0;
    end else if (drop) begin
      o_cap_overrun <= 1'b1;
    end else if (i_ovr_clr) begin
      o_cap_overrun <= 1'b0;
    end
  end

endmodule

// File: doc/counter_ir_capture.md
Name: counter_ir_capture

Overview:
Receive-side companion to the IR pulse-generator frontend. Measures an external IR/pulse input: the high time and the full period between consecutive rising edges, counted in i_clk cycles. Results are presented to the counter core through a valid/ready handshake. Sits between the external pin and the counter register block, alongside the IR frontend.

Parameters:
CNT_W, 32, width of all duration counters and result fields
SYNC_STAGES, 2, input synchronizer depth (>=2)
FILT_LEN, 3, stable-sample count for the glitch filter (used only with the optional feature)

Ports:
i_clk  input  1  clock
i_rst_n  input  1  reset, asynchronous, active-low
i_enable  input  1  capture enable; low forces IDLE
i_invert  input  1  1 = measure the low phase (input inverted before edge detect)
i_ir_din  input  1  asynchronous external IR input
i_timeout_value  input  CNT_W  abort threshold in cycles; 0 = timeout disabled
o_cap_high  output  CNT_W  captured high time (cycles)
o_cap_period  output  CNT_W  captured rising-to-rising period (cycles)
o_cap_valid  output  1  result valid
i_cap_ready  input  1  consumer accepts result
i_ovr_clr  input  1  clears o_cap_overrun
o_cap_overrun  output  1  sticky: capture dropped because the result was still pending
o_timeout  output  1  one-cycle pulse on timeout abort
o_busy  output  1  FSM not in IDLE

Behaviour:
- Reset values: all outputs 0; FSM IDLE; counters 0; synchronizer flops 0.
- Signal path: i_ir_din -> SYNC_STAGES flops -> XOR i_invert -> s. A delay flop s_d follows s.
- Edge definitions: rise = s & !s_d; fall = !s & s_d.
- Latency: a pin change reaches s after SYNC_STAGES cycles.
- Counter cnt:
  - Loaded to 1 on the cycle after a rise.
  - Otherwise increments every cycle in HIGH or LOW.
  - Saturates at all-ones with no wrap.
  - Cleared to 0 in IDLE.
- FSM state IDLE:
  - On rise with i_enable=1: go to HIGH, cnt<=1.
  - No capture is produced, because the first edge only arms the FSM.
- FSM state HIGH:
  - On fall: hi_len<=cnt, go to LOW.
  - A high of H cycles gives hi_len=H.
- FSM state LOW:
  - On rise: candidate result is high=hi_len, period=cnt. Then cnt<=1 and go to HIGH; consecutive periods are measured back to back.
  - A waveform of H high / L low cycles gives high=H, period=H+L.
- Timeout: in HIGH or LOW, if i_timeout_value!=0 and cnt==i_timeout_value, then:
  - go to IDLE;
  - pulse o_timeout for 1 cycle;
  - produce no result.
  - Timeout has priority over an edge in the same cycle.
- i_enable=0: immediate return to IDLE with cnt cleared. A pending result and its valid flag are kept. Re-enabling with s already high does not arm; the FSM waits for a fresh rise.
- Output handshake:
  - o_cap_valid stays high until a cycle with o_cap_valid & i_cap_ready.
  - o_cap_high and o_cap_period stay stable while valid.
  - New candidate while o_cap_valid=1 and i_cap_ready=0: the candidate is dropped and o_cap_overrun<=1.
  - New candidate in the same cycle as an accepting handshake: the new result is loaded, o_cap_valid stays 1, no overrun.
- o_cap_overrun is cleared by i_ovr_clr. Setting has priority over clearing when both happen in the same cycle.
- Mid-operation reset: everything returns to reset values asynchronously; no partial result is emitted.

Optional Feature:
COUNTER_IR_CAPTURE_GLITCH_FILTER_EN
- Defined: a filter sits between the synchronizer output and the XOR stage. The filtered level changes only after FILT_LEN consecutive equal samples, so pulses shorter than FILT_LEN cycles are ignored. Latency grows by FILT_LEN cycles. Both edges are delayed equally, so measured H and L are unchanged for clean input.
- Undefined: no filter; the synchronizer output feeds the XOR directly.

Test Plan:
- Clean waveform, filter off, timeout=0, i_cap_ready=1: 10 high / 30 low, repeated 4 times -> 3 results, each high=10, period=40; o_cap_overrun=0.
- Backpressure: i_cap_ready=0 across 3 periods of 5 high / 5 low -> first result high=5, period=10 is held; the two later captures are dropped and o_cap_overrun=1. Then pulse i_ovr_clr -> o_cap_overrun=0. Then raise i_cap_ready -> o_cap_valid falls after 1 cycle.
- Timeout: i_timeout_value=20, input rises and stays high for 50 cycles -> o_timeout pulses once, 20 cycles after arming; FSM returns to IDLE; no o_cap_valid.
- Invert and enable: i_invert=1, input low 7 / high 13 -> high=7, period=20. Drop i_enable mid-LOW -> o_busy=0 next cycle and the pending result is retained.
- Filter on (FILT_LEN=3): 2-cycle glitch inside a 10 high / 10 low waveform -> results are unchanged (high=10, period=20).
- Async reset asserted in HIGH -> all outputs 0 immediately; after release, the first rise only arms the FSM.
